// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction ROM port, instruction handshake to the control unit,
// redirect input and fetch status. The master modport belongs to ifetch_unit.
interface ifetch_unit_if #(
   parameter int unsigned ADDR_W = 12
);
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_dout;
   logic [31:0]       instr;
   logic [31:0]       instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              halted;
   logic              fetch_fault;
   logic [31:0]       fetch_cnt;

   modport master (
      output im_addr, instr, instr_pc, instr_valid, halted, fetch_fault, fetch_cnt,
      input  im_dout, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  im_addr, instr, instr_pc, instr_valid, halted, fetch_fault, fetch_cnt,
      output im_dout, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, latches ROM words, valid/ready handshake, redirects.
// Optional macro IFETCH_MISALIGN_TRAP_EN traps misaligned redirects instead of aligning them.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 12
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_unit_if.master bus
);

   typedef enum logic [1:0] {FETCH, VALID, HALT, TRAP} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] ipc_q, ipc_nxt;
   logic [31:0] cnt_q, cnt_nxt;
   logic        valid_q, halted_q, fault_q;
   logic        accept;
   logic        redirect_bad;
   logic [31:0] target;

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr_q;
      ipc_nxt      = ipc_q;
      cnt_nxt      = cnt_q;
      accept       = (state == VALID) && bus.instr_ready;
`ifdef IFETCH_MISALIGN_TRAP_EN
      target       = bus.redirect_pc;
      redirect_bad = |bus.redirect_pc[1:0];
`else
      target       = bus.redirect_pc & ~32'd3;
      redirect_bad = 1'b0;
`endif

      if (accept)
         cnt_nxt = cnt_q + 32'd1;

      case (state)
         FETCH: begin
            instr_nxt = bus.im_dout;
            ipc_nxt   = pc;
            state_nxt = (bus.im_dout == '0) ? HALT : VALID;
         end
         VALID: begin
            if (accept) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = FETCH;
            end
         end
         HALT, TRAP: begin
         end
         default: state_nxt = FETCH;
      endcase

      // Redirect wins over the normal sequence; a same-cycle handshake is still counted above.
      if (bus.redirect_valid) begin
         instr_nxt = instr_q;
         if (redirect_bad) begin
            state_nxt = TRAP;
            pc_nxt    = pc;
            ipc_nxt   = bus.redirect_pc;
         end else begin
            state_nxt = FETCH;
            pc_nxt    = target;
            ipc_nxt   = ipc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         instr_q  <= '0;
         ipc_q    <= RESET_PC;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         instr_q  <= instr_nxt;
         ipc_q    <= ipc_nxt;
         cnt_q    <= cnt_nxt;
         valid_q  <= (state_nxt == VALID);
         halted_q <= (state_nxt == HALT);
         fault_q  <= (state_nxt == TRAP);
      end
   end

   assign bus.im_addr     = pc[ADDR_W-1:0];
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_q;
   assign bus.fetch_cnt   = cnt_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign bus.fetch_fault = fault_q;
`else
   assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: ROM model, scoreboard queue of expected (pc, word) fetches.
module tb_ifetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] rom [1024];
   exp_t        exp_q [$];
   int          n_checks;
   int          n_fail;

   ifetch_unit_if #(.ADDR_W(12)) bus_if ();

   ifetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   assign bus_if.im_dout = rom[bus_if.im_addr[11:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input int i);
      if (i == 0) return 32'hffe1_8113;
      if (i < 42 || i == 1023) return 32'h0000_0093 | (32'(i) << 16);
      return 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.instr_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (bus_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.instr_valid); end
      n_checks++; if (bus_if.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus_if.halted); end
      n_checks++; if (bus_if.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus_if.fetch_fault); end
      n_checks++; if (bus_if.fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus_if.fetch_cnt); end
      n_checks++; if (bus_if.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus_if.instr); end
      n_checks++; if (bus_if.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", bus_if.instr_pc); end
      n_checks++; if (bus_if.im_addr !== 12'h0) begin n_fail++; $display("FAIL reset_im_addr: got %h want 0", bus_if.im_addr); end
   endtask

   task automatic test_fetch();
      int   stamp [3];
      int   got;
      exp_t e;
      for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(4 * i), word: rom_word(i)});
      bus_if.instr_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (bus_if.instr_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL fetch_pop: queue empty"); end
            else begin
               e = exp_q.pop_front();
               n_checks++;
               if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
                  n_fail++; $display("FAIL fetch_word: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
               end
            end
            stamp[got] = c;
            got++;
         end
         tick();
      end
      bus_if.instr_ready = 1'b0;
      n_checks++; if (got !== 3) begin n_fail++; $display("FAIL fetch_count_seen: got %0d want 3", got); end
      else begin
         n_checks++; if (stamp[0] !== 1) begin n_fail++; $display("FAIL fetch_latency: got %0d want 1", stamp[0]); end
         n_checks++; if (stamp[1] - stamp[0] !== 2) begin n_fail++; $display("FAIL fetch_rate1: got %0d want 2", stamp[1] - stamp[0]); end
         n_checks++; if (stamp[2] - stamp[1] !== 2) begin n_fail++; $display("FAIL fetch_rate2: got %0d want 2", stamp[2] - stamp[1]); end
      end
      n_checks++; if (bus_if.fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL fetch_cnt: got %0d want 3", bus_if.fetch_cnt); end
   endtask

   task automatic test_stall();
      bit   ok;
      exp_t e;
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_wait: got timeout want valid"); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({bus_if.instr_valid, bus_if.instr, bus_if.instr_pc, bus_if.im_addr, bus_if.fetch_cnt} !==
             {1'b1, rom_word(3), 32'd12, 12'd12, 32'd3}) begin
            n_fail++; $display("FAIL stall_hold: got v %b instr %h pc %h addr %h cnt %0d want v 1 instr %h pc c addr c cnt 3",
                               bus_if.instr_valid, bus_if.instr, bus_if.instr_pc, bus_if.im_addr, bus_if.fetch_cnt, rom_word(3));
         end
      end
      exp_q.push_back('{pc: 32'd12, word: rom_word(3)});
      bus_if.instr_ready = 1'b1;
      e = exp_q.pop_front();
      n_checks++; if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
         n_fail++; $display("FAIL stall_word: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
      end
      tick();
      bus_if.instr_ready = 1'b0;
      n_checks++; if (bus_if.fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL stall_cnt: got %0d want 4", bus_if.fetch_cnt); end
   endtask

   task automatic test_redirect_handshake();
      bit   ok;
      exp_t e;
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL redir_wait: got timeout want valid"); end
      bus_if.instr_ready    = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_00A0;
      tick();
      bus_if.instr_ready    = 1'b0;
      bus_if.redirect_valid = 1'b0;
      n_checks++; if (bus_if.fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL redir_cnt: got %0d want 5", bus_if.fetch_cnt); end
      n_checks++; if (bus_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_n1: got %b want 0", bus_if.instr_valid); end
      n_checks++; if (bus_if.im_addr !== 12'h0A0) begin n_fail++; $display("FAIL redir_addr: got %h want 0a0", bus_if.im_addr); end
      exp_q.push_back('{pc: 32'h0000_00A0, word: rom_word(40)});
      tick();
      n_checks++; if (bus_if.instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid_n2: got %b want 1", bus_if.instr_valid); end
      e = exp_q.pop_front();
      n_checks++; if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
         n_fail++; $display("FAIL redir_word: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
      end
   endtask

   task automatic test_halt();
      bit   ok;
      exp_t e;
      exp_q.push_back('{pc: 32'h0000_00A4, word: rom_word(41)});
      bus_if.instr_ready = 1'b1;
      tick();
      for (int c = 0; c < 20 && !bus_if.halted; c++) begin
         if (bus_if.instr_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL halt_pop: queue empty"); end
            else begin
               e = exp_q.pop_front();
               n_checks++;
               if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
                  n_fail++; $display("FAIL halt_word: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
               end
            end
         end
         tick();
      end
      n_checks++; if (bus_if.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", bus_if.halted); end
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL halt_pending: got %0d want 0", exp_q.size()); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({bus_if.halted, bus_if.instr_valid, bus_if.im_addr, bus_if.fetch_cnt} !== {1'b1, 1'b0, 12'h0A8, 32'd7}) begin
            n_fail++; $display("FAIL halt_hold: got h %b v %b addr %h cnt %0d want h 1 v 0 addr 0a8 cnt 7",
                               bus_if.halted, bus_if.instr_valid, bus_if.im_addr, bus_if.fetch_cnt);
         end
      end
      bus_if.instr_ready    = 1'b0;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0;
      tick();
      bus_if.redirect_valid = 1'b0;
      n_checks++; if ({bus_if.halted, bus_if.im_addr} !== {1'b0, 12'h000}) begin
         n_fail++; $display("FAIL halt_exit: got h %b addr %h want h 0 addr 000", bus_if.halted, bus_if.im_addr);
      end
      exp_q.push_back('{pc: 32'h0, word: rom_word(0)});
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL halt_restart_wait: got timeout want valid"); end
      e = exp_q.pop_front();
      n_checks++; if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
         n_fail++; $display("FAIL halt_restart: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
      end
   endtask

   task automatic test_misalign();
      bit   ok;
      exp_t e;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_0066;
      tick();
      bus_if.redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      n_checks++; if ({bus_if.fetch_fault, bus_if.instr_valid, bus_if.instr_pc, bus_if.im_addr} !== {1'b1, 1'b0, 32'h66, 12'h000}) begin
         n_fail++; $display("FAIL trap_enter: got f %b v %b ipc %h addr %h want f 1 v 0 ipc 66 addr 000",
                            bus_if.fetch_fault, bus_if.instr_valid, bus_if.instr_pc, bus_if.im_addr);
      end
      bus_if.instr_ready = 1'b1;
      tick();
      tick();
      bus_if.instr_ready = 1'b0;
      n_checks++; if ({bus_if.fetch_fault, bus_if.fetch_cnt} !== {1'b1, 32'd7}) begin
         n_fail++; $display("FAIL trap_hold: got f %b cnt %0d want f 1 cnt 7", bus_if.fetch_fault, bus_if.fetch_cnt);
      end
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_0064;
      tick();
      bus_if.redirect_valid = 1'b0;
      n_checks++; if (bus_if.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL trap_exit: got %b want 0", bus_if.fetch_fault); end
`else
      n_checks++; if ({bus_if.fetch_fault, bus_if.instr_valid, bus_if.im_addr} !== {1'b0, 1'b0, 12'h064}) begin
         n_fail++; $display("FAIL align_redirect: got f %b v %b addr %h want f 0 v 0 addr 064",
                            bus_if.fetch_fault, bus_if.instr_valid, bus_if.im_addr);
      end
`endif
      exp_q.push_back('{pc: 32'h0000_0064, word: rom_word(25)});
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL misalign_wait: got timeout want valid"); end
      e = exp_q.pop_front();
      n_checks++; if ({bus_if.instr_pc, bus_if.instr, bus_if.fetch_cnt} !== {e.pc, e.word, 32'd7}) begin
         n_fail++; $display("FAIL misalign_word: got pc %h instr %h cnt %0d want pc %h instr %h cnt 7",
                            bus_if.instr_pc, bus_if.instr, bus_if.fetch_cnt, e.pc, e.word);
      end
   endtask

   task automatic test_reset_mid();
      rst                   = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_00A0;
      bus_if.instr_ready    = 1'b1;
      tick();
      rst                   = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.instr_ready    = 1'b0;
      n_checks++;
      if ({bus_if.instr_valid, bus_if.halted, bus_if.fetch_fault, bus_if.fetch_cnt, bus_if.instr, bus_if.instr_pc, bus_if.im_addr} !==
          {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h000}) begin
         n_fail++; $display("FAIL rst_mid: got v %b h %b f %b cnt %h instr %h ipc %h addr %h want all zero",
                            bus_if.instr_valid, bus_if.halted, bus_if.fetch_fault, bus_if.fetch_cnt, bus_if.instr, bus_if.instr_pc, bus_if.im_addr);
      end
      tick();
      n_checks++; if ({bus_if.instr_valid, bus_if.instr_pc, bus_if.instr} !== {1'b1, 32'h0, rom_word(0)}) begin
         n_fail++; $display("FAIL rst_mid_refetch: got v %b ipc %h instr %h want v 1 ipc 0 instr %h",
                            bus_if.instr_valid, bus_if.instr_pc, bus_if.instr, rom_word(0));
      end
   endtask

   task automatic test_wrap();
      int   got;
      exp_t e;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus_if.redirect_valid = 1'b0;
      n_checks++; if (bus_if.im_addr !== 12'hFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want ffc", bus_if.im_addr); end
      exp_q.push_back('{pc: 32'hFFFF_FFFC, word: rom_word(1023)});
      exp_q.push_back('{pc: 32'h0, word: rom_word(0)});
      bus_if.instr_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (bus_if.instr_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_pop: queue empty"); end
            else begin
               e = exp_q.pop_front();
               n_checks++;
               if ({bus_if.instr_pc, bus_if.instr} !== {e.pc, e.word}) begin
                  n_fail++; $display("FAIL wrap_word: got pc %h instr %h want pc %h instr %h", bus_if.instr_pc, bus_if.instr, e.pc, e.word);
               end
            end
            got++;
         end
         tick();
      end
      bus_if.instr_ready = 1'b0;
      n_checks++; if ({bus_if.fetch_cnt, bus_if.im_addr} !== {32'd2, 12'h004}) begin
         n_fail++; $display("FAIL wrap_end: got cnt %0d addr %h want cnt 2 addr 004", bus_if.fetch_cnt, bus_if.im_addr);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 1024; i++) rom[i] = rom_word(i);
      rst                   = 1'b1;
      bus_if.instr_ready    = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = 32'h0;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect_handshake();
      test_halt();
      test_misalign();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
